img_loader: RTL and testbench

- Upstream feeder of the CNN datapath.
- Accepts a 28x28 8-bit input image from the HPS over an Avalon-MM slave, 4 pixels per 32-bit word.
- Serialises each word into single-pixel writes broadcast to both redundant image memories (copies 0 and 1).
- Sequences start/done with the CNN core and exposes the classified digit and an interrupt to software.

---
 rtl/cnn_pkg.sv | 19 +
 rtl/pixel_serializer.sv | 40 ++++
 rtl/img_loader.sv | 104 ++++++++++
 tb/tb_img_loader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// cnn_pkg: shared image geometry, loader register map and loader FSM states
package cnn_pkg;
    localparam int IMG_W      = 28;
    localparam int IMG_H      = 28;
    localparam int PIX_W      = 8;
    localparam int IMG_PIXELS = IMG_W * IMG_H;
    localparam int IMG_WORDS  = IMG_PIXELS / 4;

    localparam logic [8:0] ADDR_CTRL   = 9'd256;
    localparam logic [8:0] ADDR_STATUS = 9'd257;
    localparam logic [8:0] ADDR_RESULT = 9'd258;

    localparam int CTRL_START   = 0;
    localparam int CTRL_CLEAR   = 1;
    localparam int CTRL_IRQ_EN  = 2;
    localparam int CTRL_IRQ_ACK = 3;

    typedef enum logic [1:0] {IDLE, SER, RUN, DONE} loader_state_t;
endpackage

// File: rtl/pixel_serializer.sv
// pixel_serializer: turns one latched 32-bit word into four consecutive pixel writes
module pixel_serializer
    import cnn_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [7:0]       word,
    input  logic [31:0]      data,
    output logic             wr_en,
    output logic [9:0]       wr_addr,
    output logic [PIX_W-1:0] wr_data,
    output logic             last
);
    logic [31:0] data_q;
    logic [1:0]  beat;
    logic [9:0]  base;

    // a load restarts the beat sequence, even on the last beat of the previous word
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_en  <= 1'b0;
            beat   <= 2'd0;
            base   <= 10'd0;
            data_q <= 32'd0;
        end else if (load) begin
            wr_en  <= 1'b1;
            beat   <= 2'd0;
            base   <= {word, 2'b00};
            data_q <= data;
        end else if (wr_en) begin
            wr_en <= beat != 2'd3;
            beat  <= beat + 2'd1;
        end
    end

    assign last    = wr_en && beat == 2'd3;
    assign wr_addr = base + {8'd0, beat};
    assign wr_data = data_q[{beat, 3'b000} +: PIX_W];
endmodule

// File: rtl/img_loader.sv
// img_loader: Avalon-MM image loader feeding both image memory copies and sequencing the CNN core
module img_loader
    import cnn_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic [8:0]       avs_address,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    input  logic             avs_read,
    output logic [31:0]      avs_readdata,
    output logic             avs_waitrequest,
    output logic             img_wr_en,
    output logic [9:0]       img_wr_addr,
    output logic [PIX_W-1:0] img_wr_data,
    output logic             cnn_start,
    input  logic             cnn_done,
    input  logic [3:0]       cnn_digit,
    output logic             irq
);
    loader_state_t state;
    logic [7:0]  word_cnt, cnt_clr;
    logic [3:0]  res_digit;
    logic [31:0] rd_mux;
    logic        err, irq_en, res_valid;
    logic        ser_last, acc, wr, rd, run, pix_wr, ctrl_wr, clr, start_req, start_ok, load, done_ev, ack;

    // the last serialiser beat already counts as idle, so a stalled request lands right as SER ends
    assign acc             = state != SER || ser_last;
    assign avs_waitrequest = !acc && (avs_write || avs_read);
    assign wr              = avs_write && acc;
    assign rd              = avs_read && acc;
    assign run             = state == RUN;
    assign pix_wr          = wr && avs_address < 9'(IMG_WORDS);
    assign ctrl_wr         = wr && avs_address == ADDR_CTRL;
    assign clr             = ctrl_wr && avs_writedata[CTRL_CLEAR];
    assign ack             = ctrl_wr && avs_writedata[CTRL_IRQ_ACK];
    assign cnt_clr         = clr ? 8'd0 : word_cnt;
    assign start_req       = ctrl_wr && avs_writedata[CTRL_START];
    assign start_ok        = start_req && !run && cnt_clr == 8'(IMG_WORDS);
    assign load            = pix_wr && !run;
    assign done_ev         = cnn_done && run;

    pixel_serializer u_ser (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .word    (avs_address[7:0]),
        .data    (avs_writedata),
        .wr_en   (img_wr_en),
        .wr_addr (img_wr_addr),
        .wr_data (img_wr_data),
        .last    (ser_last)
    );

    // every accepted pixel word passes through SER; start and done move between RUN and DONE
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else if (load)
            state <= SER;
        else if (start_ok)
            state <= RUN;
        else if (done_ev)
            state <= DONE;
        else if (state == SER && ser_last)
            state <= IDLE;
    end

    // software-visible registers; an err set in the same cycle as a clear wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_cnt  <= 8'd0;
            err       <= 1'b0;
            irq_en    <= 1'b0;
            irq       <= 1'b0;
            cnn_start <= 1'b0;
            res_digit <= 4'd0;
            res_valid <= 1'b0;
        end else begin
            word_cnt  <= load && cnt_clr != 8'(IMG_WORDS) ? cnt_clr + 8'd1 : cnt_clr;
            err       <= (err && !clr) || (start_req && !start_ok) || (pix_wr && run) || (done_ev && cnn_digit > 4'd9);
            irq_en    <= irq_en || (ctrl_wr && avs_writedata[CTRL_IRQ_EN]);
            irq       <= done_ev ? irq_en : irq && !(load || start_ok || ack);
            cnn_start <= start_ok;
            if (done_ev) begin
                res_digit <= cnn_digit;
                res_valid <= 1'b1;
            end
        end
    end

    assign rd_mux = avs_write ? 32'd0 :
                    avs_address == ADDR_STATUS ? {16'd0, word_cnt, 5'd0, err, state == DONE, state == SER || run} :
                    avs_address == ADDR_RESULT ? {res_valid, 27'd0, res_digit} : 32'd0;

    // read data is registered and held until the next accepted read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            avs_readdata <= 32'd0;
        else if (rd)
            avs_readdata <= rd_mux;
    end
endmodule

// File: tb/tb_img_loader.sv
// tb_img_loader: randomized transaction-level check of img_loader against a behavioural model
module tb_img_loader;
    logic        clk = 0, reset_n = 1;
    logic [8:0]  avs_address = 0;
    logic        avs_write = 0, avs_read = 0;
    logic [31:0] avs_writedata = 0;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest, img_wr_en, cnn_start, irq;
    logic [9:0]  img_wr_addr;
    logic [7:0]  img_wr_data;
    logic        cnn_done = 0;
    logic [3:0]  cnn_digit = 0;

    int checks = 0, errors = 0, cyc = 0;
    // behavioural model: mode 0 idle, 1 running, 2 result held
    int m_cnt = 0, m_mode = 0, ser_free = -100, last_stalls = 0;
    bit m_err = 0, m_irq_en = 0, m_irq = 0, m_valid = 0, exp_start = 0;
    logic [3:0]  m_digit = 0;
    logic [31:0] last_rd = 0;
    int pix_q[$];

    img_loader dut (
        .clk(clk), .reset_n(reset_n), .avs_address(avs_address), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_read(avs_read), .avs_readdata(avs_readdata),
        .avs_waitrequest(avs_waitrequest), .img_wr_en(img_wr_en), .img_wr_addr(img_wr_addr),
        .img_wr_data(img_wr_data), .cnn_start(cnn_start), .cnn_done(cnn_done),
        .cnn_digit(cnn_digit), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // per-cycle comparison of pixel stream, start pulse and irq level
    always @(negedge clk) begin
        int e;
        if (reset_n) begin
            if (img_wr_en) begin
                if (pix_q.size() == 0)
                    check("spurious_pix_wr", 32'(img_wr_en), 32'd0);
                else begin
                    e = pix_q.pop_front();
                    check("pix_addr", 32'(img_wr_addr), 32'(e / 256));
                    check("pix_data", 32'(img_wr_data), 32'(e % 256));
                end
            end
            check("cnn_start", 32'(cnn_start), 32'(exp_start));
            exp_start = 0;
            check("irq", 32'(irq), 32'(m_irq));
        end
    end

    // present one request and hold it until accepted; acceptance edge is predicted by the model
    task automatic xfer(input bit w, input bit r, input logic [8:0] a, input logic [31:0] d, output int edge_n);
        int p, exp_edge, budget;
        bit ws;
        p = cyc;
        exp_edge = ser_free > p + 1 ? ser_free : p + 1;
        budget = 0;
        avs_write = w; avs_read = r; avs_address = a; avs_writedata = d;
        do begin
            @(negedge clk); ws = avs_waitrequest;
            @(posedge clk); #1; budget++;
        end while (ws && budget < 20);
        avs_write = 0; avs_read = 0;
        edge_n = cyc;
        last_stalls = edge_n - p - 1;
        check("accept_edge", 32'(edge_n), 32'(exp_edge));
    endtask

    task automatic wr(input logic [8:0] a, input logic [31:0] d, input bit with_rd);
        int x;
        xfer(1, with_rd, a, d, x);
        if (a < 196) begin
            if (m_mode == 1) m_err = 1;
            else begin
                m_cnt = m_cnt < 196 ? m_cnt + 1 : 196;
                m_mode = 0; m_irq = 0; ser_free = x + 4;
                for (int k = 0; k < 4; k++) pix_q.push_back((a * 4 + k) * 256 + ((d >> (8 * k)) & 255));
            end
        end else if (a == 256) begin
            if (d[1]) begin m_cnt = 0; m_err = 0; end
            if (d[2]) m_irq_en = 1;
            if (d[3]) m_irq = 0;
            if (d[0]) begin
                if (m_mode != 1 && m_cnt == 196) begin m_mode = 1; exp_start = 1; m_irq = 0; end
                else m_err = 1;
            end
        end
        if (with_rd) begin
            @(negedge clk); check("wr_rd_zero", avs_readdata, 32'd0); last_rd = 0;
            @(posedge clk); #1;
        end
    endtask

    task automatic rd(input logic [8:0] a, output logic [31:0] got);
        int x;
        bit busy;
        logic [31:0] e;
        xfer(0, 1, a, 0, x);
        busy = m_mode == 1 || (x >= ser_free - 3 && x <= ser_free);
        e = a == 257 ? 32'(m_cnt * 256 + (m_err ? 4 : 0) + (m_mode == 2 ? 2 : 0) + (busy ? 1 : 0)) :
            a == 258 ? ((m_valid ? 32'h8000_0000 : 32'd0) | 32'(m_digit)) : 32'd0;
        @(negedge clk); got = avs_readdata; check("readdata", got, e); last_rd = e;
        @(posedge clk); #1;
    endtask

    task automatic done_pulse(input logic [3:0] dg);
        cnn_done = 1; cnn_digit = dg;
        @(posedge clk); #1; cnn_done = 0;
        if (m_mode == 1) begin
            m_digit = dg; m_valid = 1; m_mode = 2; m_irq = m_irq_en;
            if (dg > 9) m_err = 1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); check("rd_hold", avs_readdata, last_rd);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] v, d;
        int op;
        #2 reset_n = 0;
        #1;
        check("rst_readdata", avs_readdata, 32'd0);
        check("rst_wait", 32'(avs_waitrequest), 32'd0);
        check("rst_wr_en", 32'(img_wr_en), 32'd0);
        check("rst_wr_addr", 32'(img_wr_addr), 32'd0);
        check("rst_start", 32'(cnn_start), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        @(posedge clk); #1 reset_n = 1;
        idle(2);
        // single word: four pixel beats at addresses 20..23
        wr(9'd5, 32'h0403_0201, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("lit_wr_en", 32'(img_wr_en), 32'd1);
            check("lit_addr", 32'(img_wr_addr), 32'(20 + k));
            check("lit_data", 32'(img_wr_data), 32'(k + 1));
            @(posedge clk); #1;
        end
        wr(9'd7, 32'h1122_3344, 0);
        wr(9'd6, 32'h0807_0605, 0);
        check("lit_b2b_stalls", 32'(last_stalls), 32'd3);
        idle(5);
        rd(9'd257, v); check("lit_status_cnt3", v, 32'h0000_0300);
        // start with too few words, then clear; start+clear together leaves err set
        wr(9'd256, 32'h1, 0);
        rd(9'd257, v); check("lit_status_err", v, 32'h0000_0304);
        wr(9'd256, 32'h2, 0);
        rd(9'd257, v); check("lit_status_clr", v, 32'h0000_0000);
        wr(9'd256, 32'h3, 0);
        rd(9'd257, v); check("lit_start_clr", v, 32'h0000_0004);
        wr(9'd256, 32'h2, 0);
        // full image, irq enable, start
        for (int i = 0; i < 196; i++) wr(9'(i), $urandom, 0);
        wr(9'd256, 32'h4, 0);
        wr(9'd256, 32'h1, 0);
        @(negedge clk); check("lit_start_pulse", 32'(cnn_start), 32'd1);
        @(posedge clk); #1;
        rd(9'd257, v); check("lit_status_run", v, 32'h0000_C401);
        wr(9'd3, 32'hDEAD_BEEF, 0);
        idle(5);
        rd(9'd257, v); check("lit_status_run_err", v, 32'h0000_C405);
        done_pulse(4'd7);
        @(negedge clk); check("lit_irq_set", 32'(irq), 32'd1);
        @(posedge clk); #1;
        rd(9'd258, v); check("lit_result", v, 32'h8000_0007);
        rd(9'd257, v); check("lit_status_done", v, 32'h0000_C406);
        wr(9'd256, 32'h8, 0);
        @(negedge clk); check("lit_irq_ack", 32'(irq), 32'd0);
        @(posedge clk); #1;
        wr(9'd256, 32'h2, 0);
        done_pulse(4'd3);
        rd(9'd258, v); check("lit_result_held", v, 32'h8000_0007);
        wr(9'd258, 32'hFFFF_FFFF, 1);
        // randomized traffic
        for (int round = 0; round < 3; round++) begin
            wr(9'd256, 32'h2, 0);
            for (int n = 0; n < 400; n++) begin
                op = $urandom_range(0, 99);
                if (op < 55) wr(9'($urandom_range(0, 195)), $urandom, 0);
                else if (op < 65) wr(9'($urandom_range(196, 511)), $urandom, 0);
                else if (op < 75) begin
                    d = 0;
                    d[0] = $urandom_range(0, 1) == 1;
                    d[1] = $urandom_range(0, 19) == 0;
                    d[2] = $urandom_range(0, 3) == 0;
                    d[3] = $urandom_range(0, 2) == 0;
                    wr(9'd256, d, 0);
                end else if (op < 90) begin
                    op = $urandom_range(0, 2);
                    rd(op == 0 ? 9'd257 : op == 1 ? 9'd258 : 9'($urandom_range(0, 511)), v);
                end else done_pulse(4'($urandom_range(0, 15)));
                if ($urandom_range(0, 9) < 6) idle($urandom_range(1, 2));
            end
        end
        // reset during serialiser beat 2
        done_pulse(4'd1);
        wr(9'd5, 32'hAABB_CCDD, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_wr_en", 32'(img_wr_en), 32'd1);
        reset_n = 0;
        #1;
        check("mid_rst_wr_en", 32'(img_wr_en), 32'd0);
        check("mid_rst_irq", 32'(irq), 32'd0);
        check("mid_rst_readdata", avs_readdata, 32'd0);
        m_cnt = 0; m_mode = 0; m_err = 0; m_irq_en = 0; m_irq = 0; m_valid = 0; m_digit = 0;
        exp_start = 0; last_rd = 0; ser_free = -100;
        pix_q.delete();
        @(posedge clk); #1 reset_n = 1;
        rd(9'd257, v); check("lit_post_rst_status", v, 32'd0);
        rd(9'd258, v); check("lit_post_rst_result", v, 32'd0);
        idle(6);
        check("pix_q_drained", 32'(pix_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
